// File: rtl/parameterized_signed_alu_pkg.sv
// -----------------------------------------------------------------------------
// parameterized_signed_alu_pkg
// Shared definitions for the registered signed ALU:
//   - default operand / result widths
//   - 4-bit opcode encodings (ALU_ADD .. ALU_SHL_B)
//   - compare result codes (CMP_EQ / CMP_GT / CMP_LT)
//   - opcode group field values (alu_fn[3:2]) and the unit-enable bundle
// -----------------------------------------------------------------------------
package parameterized_signed_alu_pkg;

  localparam int DEF_IN_DATA_WIDTH    = 16;
  localparam int DEF_OUT_DATA_WIDTH   = 16;
  localparam int DEF_ARITH_DATA_WIDTH = 32;

  // Arithmetic group
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_MUL   = 4'd2;
  localparam logic [3:0] ALU_DIV   = 4'd3;
  // Logic group
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_NAND  = 4'd6;
  localparam logic [3:0] ALU_NOR   = 4'd7;
  // Compare group (opcode 8 sits in this group but is a NOP)
  localparam logic [3:0] ALU_NOP   = 4'd8;
  localparam logic [3:0] ALU_EQ    = 4'd9;
  localparam logic [3:0] ALU_GT    = 4'd10;
  localparam logic [3:0] ALU_LT    = 4'd11;
  // Shift group (logical, amount 1)
  localparam logic [3:0] ALU_SHR_A = 4'd12;
  localparam logic [3:0] ALU_SHL_A = 4'd13;
  localparam logic [3:0] ALU_SHR_B = 4'd14;
  localparam logic [3:0] ALU_SHL_B = 4'd15;

  // Compare result codes
  localparam logic [1:0] CMP_EQ = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;
  localparam logic [1:0] CMP_LT = 2'd3;

  // Opcode group field alu_fn[3:2]
  localparam logic [1:0] GRP_ARITH = 2'd0;
  localparam logic [1:0] GRP_LOGIC = 2'd1;
  localparam logic [1:0] GRP_CMP   = 2'd2;
  localparam logic [1:0] GRP_SHIFT = 2'd3;

  // One-hot (or all-zero for NOP) functional unit enables
  typedef struct packed {
    logic arith_en;
    logic logic_en;
    logic cmp_en;
    logic shift_en;
  } unit_en_t;

endpackage

// File: rtl/parameterized_signed_alu_alu_fn_decoder.sv
// -----------------------------------------------------------------------------
// parameterized_signed_alu_alu_fn_decoder
// Maps the opcode group alu_fn[3:2] onto the four functional-unit enables.
// Opcode 8 (NOP) lives in the compare group but enables no unit.
// Ports:
//   alu_fn   in  4          opcode
//   unit_en  out unit_en_t  {arith_en, logic_en, cmp_en, shift_en}
// -----------------------------------------------------------------------------
module parameterized_signed_alu_alu_fn_decoder
  import parameterized_signed_alu_pkg::*;
(
  input  logic [3:0] alu_fn,
  output unit_en_t   unit_en
);

  // Group decode with the NOP carve-out
  always_comb begin
    unit_en = '0;
    case (alu_fn[3:2])
      GRP_ARITH: unit_en.arith_en = 1'b1;
      GRP_LOGIC: unit_en.logic_en = 1'b1;
      GRP_CMP: begin
        if (alu_fn == ALU_NOP) begin
          unit_en.cmp_en = 1'b0;
        end else begin
          unit_en.cmp_en = 1'b1;
        end
      end
      GRP_SHIFT: unit_en.shift_en = 1'b1;
      default:   unit_en = '0;
    endcase
  end

endmodule

// File: rtl/parameterized_signed_alu.sv
// -----------------------------------------------------------------------------
// parameterized_signed_alu
// Registered signed ALU with arithmetic, logic, compare and shift units.
// One opcode per cycle; only the selected unit's result and flag are loaded,
// every other unit's result and flag are cleared on the same edge.
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-low reset
//   A, B        in   IN     two's-complement operands
//   alu_fn      in   4      opcode (see package)
//   arith_out   out  ARITH  signed add/sub/mul/div result
//   carry_out   out  1      carry (ADD) / borrow (SUB)
//   logic_out   out  OUT    bitwise result
//   cmp_out     out  OUT    compare code
//   shift_out   out  OUT    shift-by-one result
//   *_flag      out  1      corresponding output valid this cycle
// ARITH_OUT_DATA_WIDTH must be >= 2*IN_DATA_WIDTH so the product fits.
// -----------------------------------------------------------------------------
module parameterized_signed_alu
  import parameterized_signed_alu_pkg::*;
#(
  parameter int IN_DATA_WIDTH        = DEF_IN_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH       = DEF_OUT_DATA_WIDTH,
  parameter int ARITH_OUT_DATA_WIDTH = DEF_ARITH_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_DATA_WIDTH-1:0]        A,
  input  logic [IN_DATA_WIDTH-1:0]        B,
  input  logic [3:0]                      alu_fn,
  output logic [ARITH_OUT_DATA_WIDTH-1:0] arith_out,
  output logic                            carry_out,
  output logic [OUT_DATA_WIDTH-1:0]       logic_out,
  output logic [OUT_DATA_WIDTH-1:0]       cmp_out,
  output logic [OUT_DATA_WIDTH-1:0]       shift_out,
  output logic                            arith_flag,
  output logic                            logic_flag,
  output logic                            cmp_flag,
  output logic                            shift_flag
);

  localparam int IW     = IN_DATA_WIDTH;
  localparam int OW     = OUT_DATA_WIDTH;
  localparam int AW     = ARITH_OUT_DATA_WIDTH;
  localparam int PROD_W = 2 * IN_DATA_WIDTH;
  // One extra bit so that MIN / -1 is representable
  localparam int DIV_W  = IN_DATA_WIDTH + 1;
  localparam int FIT_W  = (IN_DATA_WIDTH > OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;

  // Zero-extend or truncate an operand-width vector to the output width
  function automatic logic [OW-1:0] fit_out(input logic [IW-1:0] v);
    logic [FIT_W-1:0] wide;
    wide        = '0;
    wide[IW-1:0] = v;
    return wide[OW-1:0];
  endfunction

  unit_en_t unit_en;

  parameterized_signed_alu_alu_fn_decoder u_dec (
    .alu_fn  (alu_fn),
    .unit_en (unit_en)
  );

  // Unit results
  logic [AW-1:0]           add_res, sub_res, mul_res, div_res;
  logic [IW:0]             add_u, sub_u;
  logic signed [PROD_W-1:0] prod;
  logic signed [DIV_W-1:0]  a_div, b_div, quo;

  // Register next-state values
  logic [AW-1:0] arith_out_d, arith_out_q;
  logic          carry_out_d, carry_out_q;
  logic [OW-1:0] logic_out_d, logic_out_q;
  logic [OW-1:0] cmp_out_d,   cmp_out_q;
  logic [OW-1:0] shift_out_d, shift_out_q;
  logic          arith_flag_d, arith_flag_q;
  logic          logic_flag_d, logic_flag_q;
  logic          cmp_flag_d,   cmp_flag_q;
  logic          shift_flag_d, shift_flag_q;

  // Arithmetic unit: full-precision signed results plus unsigned carry/borrow
  always_comb begin
    add_res = AW'($signed(A)) + AW'($signed(B));
    sub_res = AW'($signed(A)) - AW'($signed(B));
    // Bit IW of the zero-extended sum/difference is the carry/borrow
    add_u   = {1'b0, A} + {1'b0, B};
    sub_u   = {1'b0, A} - {1'b0, B};
    prod    = PROD_W'($signed(A)) * PROD_W'($signed(B));
    mul_res = AW'(prod);
    a_div   = DIV_W'($signed(A));
    b_div   = DIV_W'($signed(B));
    if (B == '0) begin
      quo = '0;
    end else begin
      quo = a_div / b_div;
    end
    div_res = AW'(quo);
  end

  // Output select: selected unit loads its result, all others clear
  always_comb begin
    arith_out_d  = '0;
    carry_out_d  = 1'b0;
    logic_out_d  = '0;
    cmp_out_d    = '0;
    shift_out_d  = '0;
    arith_flag_d = unit_en.arith_en;
    logic_flag_d = unit_en.logic_en;
    cmp_flag_d   = unit_en.cmp_en;
    shift_flag_d = unit_en.shift_en;
    case (alu_fn)
      ALU_ADD: begin
        arith_out_d = add_res;
        carry_out_d = add_u[IW];
      end
      ALU_SUB: begin
        arith_out_d = sub_res;
        carry_out_d = sub_u[IW];
      end
      ALU_MUL:   arith_out_d = mul_res;
      ALU_DIV:   arith_out_d = div_res;
      ALU_AND:   logic_out_d = fit_out(A & B);
      ALU_OR:    logic_out_d = fit_out(A | B);
      ALU_NAND:  logic_out_d = fit_out(~(A & B));
      ALU_NOR:   logic_out_d = fit_out(~(A | B));
      ALU_NOP:   arith_out_d = '0;
      ALU_EQ: begin
        if (A == B) begin
          cmp_out_d = OW'(CMP_EQ);
        end else begin
          cmp_out_d = '0;
        end
      end
      ALU_GT: begin
        if ($signed(A) > $signed(B)) begin
          cmp_out_d = OW'(CMP_GT);
        end else begin
          cmp_out_d = '0;
        end
      end
      ALU_LT: begin
        if ($signed(A) < $signed(B)) begin
          cmp_out_d = OW'(CMP_LT);
        end else begin
          cmp_out_d = '0;
        end
      end
      ALU_SHR_A: shift_out_d = fit_out(A >> 1'b1);
      ALU_SHL_A: shift_out_d = fit_out(A << 1'b1);
      ALU_SHR_B: shift_out_d = fit_out(B >> 1'b1);
      ALU_SHL_B: shift_out_d = fit_out(B << 1'b1);
      default: begin
        arith_out_d = '0;
        carry_out_d = 1'b0;
      end
    endcase
  end

  // Output registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arith_out_q  <= '0;
      carry_out_q  <= 1'b0;
      logic_out_q  <= '0;
      cmp_out_q    <= '0;
      shift_out_q  <= '0;
      arith_flag_q <= 1'b0;
      logic_flag_q <= 1'b0;
      cmp_flag_q   <= 1'b0;
      shift_flag_q <= 1'b0;
    end else begin
      arith_out_q  <= arith_out_d;
      carry_out_q  <= carry_out_d;
      logic_out_q  <= logic_out_d;
      cmp_out_q    <= cmp_out_d;
      shift_out_q  <= shift_out_d;
      arith_flag_q <= arith_flag_d;
      logic_flag_q <= logic_flag_d;
      cmp_flag_q   <= cmp_flag_d;
      shift_flag_q <= shift_flag_d;
    end
  end

  assign arith_out  = arith_out_q;
  assign carry_out  = carry_out_q;
  assign logic_out  = logic_out_q;
  assign cmp_out    = cmp_out_q;
  assign shift_out  = shift_out_q;
  assign arith_flag = arith_flag_q;
  assign logic_flag = logic_flag_q;
  assign cmp_flag   = cmp_flag_q;
  assign shift_flag = shift_flag_q;

endmodule

// File: tb/tb_parameterized_signed_alu.sv
// -----------------------------------------------------------------------------
// tb_parameterized_signed_alu
// Directed, scoreboard-based bench for parameterized_signed_alu (default
// widths 16/16/32). Expected results come from an integer reference model.
// -----------------------------------------------------------------------------
module tb_parameterized_signed_alu;

  typedef struct packed {
    logic [31:0] arith;
    logic        carry;
    logic [15:0] lo;
    logic [15:0] cmp;
    logic [15:0] sh;
    logic [3:0]  flags;  // {arith, logic, cmp, shift}
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  alu_fn;
  logic [31:0] arith_out;
  logic        carry_out;
  logic [15:0] logic_out;
  logic [15:0] cmp_out;
  logic [15:0] shift_out;
  logic        arith_flag;
  logic        logic_flag;
  logic        cmp_flag;
  logic        shift_flag;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  parameterized_signed_alu #(
    .IN_DATA_WIDTH        (16),
    .OUT_DATA_WIDTH       (16),
    .ARITH_OUT_DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .alu_fn     (alu_fn),
    .arith_out  (arith_out),
    .carry_out  (carry_out),
    .logic_out  (logic_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .arith_flag (arith_flag),
    .logic_flag (logic_flag),
    .cmp_flag   (cmp_flag),
    .shift_flag (shift_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic
  function automatic exp_t model(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int sa;
    int sb;
    int ua;
    int ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'({16'h0000, a});
    ub = int'({16'h0000, b});
    e  = '0;
    case (fn)
      4'd0:  begin e.arith = sa + sb; e.carry = (ua + ub) > 65535; e.flags = 4'b1000; end
      4'd1:  begin e.arith = sa - sb; e.carry = (ua < ub);         e.flags = 4'b1000; end
      4'd2:  begin e.arith = sa * sb;                               e.flags = 4'b1000; end
      4'd3:  begin e.arith = (sb == 0) ? 0 : sa / sb;               e.flags = 4'b1000; end
      4'd4:  begin e.lo = a & b;     e.flags = 4'b0100; end
      4'd5:  begin e.lo = a | b;     e.flags = 4'b0100; end
      4'd6:  begin e.lo = ~(a & b);  e.flags = 4'b0100; end
      4'd7:  begin e.lo = ~(a | b);  e.flags = 4'b0100; end
      4'd8:  e = '0;
      4'd9:  begin e.cmp = (sa == sb) ? 16'd1 : 16'd0; e.flags = 4'b0010; end
      4'd10: begin e.cmp = (sa > sb)  ? 16'd2 : 16'd0; e.flags = 4'b0010; end
      4'd11: begin e.cmp = (sa < sb)  ? 16'd3 : 16'd0; e.flags = 4'b0010; end
      4'd12: begin e.sh = a >> 1; e.flags = 4'b0001; end
      4'd13: begin e.sh = a << 1; e.flags = 4'b0001; end
      4'd14: begin e.sh = b >> 1; e.flags = 4'b0001; end
      default: begin e.sh = b << 1; e.flags = 4'b0001; end
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".arith"}, arith_out, e.arith);
    check({tag, ".carry"}, 32'(carry_out), 32'(e.carry));
    check({tag, ".logic"}, 32'(logic_out), 32'(e.lo));
    check({tag, ".cmp"},   32'(cmp_out),   32'(e.cmp));
    check({tag, ".shift"}, 32'(shift_out), 32'(e.sh));
    check({tag, ".flags"}, 32'({arith_flag, logic_flag, cmp_flag, shift_flag}), 32'(e.flags));
  endtask

  // Pop the oldest expectation and compare it with the current outputs
  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, observed arith=0x%0h expected an entry", tag, arith_out);
    end else begin
      e = sb_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  // Drive one operation, record its expectation, compare after the edge
  task automatic do_op(input string tag, input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    alu_fn = fn;
    A      = a;
    B      = b;
    sb_q.push_back(model(fn, a, b));
    @(posedge clk);
    #1;
    pop_compare(tag);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held across edges with arbitrary inputs
    rst    = 1'b0;
    A      = 16'h1234;
    B      = 16'h8765;
    alu_fn = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold", exp_t'(0));
    @(negedge clk);
    rst = 1'b1;

    // ADD / SUB
    do_op("add_m5_m55",  4'd0, -16'sd5, -16'sd55);
    check("add_plan_value", arith_out, 32'hFFFF_FFC4);
    do_op("add_5_m55",   4'd0, 16'sd5,  -16'sd55);
    do_op("sub_5_m55",   4'd1, 16'sd5,  -16'sd55);
    do_op("sub_5_55",    4'd1, 16'sd5,   16'sd55);
    do_op("sub_m5_m55",  4'd1, -16'sd5, -16'sd55);

    // MUL / DIV
    do_op("mul_m5_m55",  4'd2, -16'sd5, -16'sd55);
    do_op("mul_5_m55",   4'd2, 16'sd5,  -16'sd55);
    do_op("mul_max",     4'd2, 16'h8000, 16'h8000);
    do_op("div_55_m5",   4'd3, 16'sd55, -16'sd5);
    do_op("div_m30_10",  4'd3, -16'sd30, 16'sd10);
    do_op("div_100_5",   4'd3, 16'sd100, 16'sd5);
    do_op("div_m5_m55",  4'd3, -16'sd5, -16'sd55);
    do_op("div_by_zero", 4'd3, 16'sd77,  16'sd0);
    do_op("div_min_m1",  4'd3, 16'h8000, 16'hFFFF);
    check("div_min_plan_value", arith_out, 32'h0000_8000);

    // Logic and NOP
    do_op("and",  4'd4, 16'd25, 16'd94);
    do_op("or",   4'd5, 16'd25, 16'd94);
    do_op("nand", 4'd6, 16'd25, 16'd94);
    check("nand_plan_value", 32'(logic_out), 32'h0000_FFE7);
    do_op("nor",  4'd7, 16'd25, 16'd94);
    do_op("nop",  4'd8, 16'd25, 16'd94);

    // Compare
    do_op("eq_25_94",   4'd9,  16'd25,  16'd94);
    do_op("gt_25_94",   4'd10, 16'd25,  16'd94);
    do_op("lt_25_94",   4'd11, 16'd25,  16'd94);
    do_op("eq_94_30",   4'd9,  16'd94,  16'd30);
    do_op("gt_94_30",   4'd10, 16'd94,  16'd30);
    do_op("lt_94_30",   4'd11, 16'd94,  16'd30);
    do_op("eq_100_100", 4'd9,  16'd100, 16'd100);
    do_op("gt_100_100", 4'd10, 16'd100, 16'd100);
    do_op("lt_100_100", 4'd11, 16'd100, 16'd100);
    do_op("gt_signed",  4'd10, 16'sd3,  -16'sd4);

    // Shift, including discarded shift-out bits
    do_op("shr_a", 4'd12, 16'd25, 16'd94);
    do_op("shl_a", 4'd13, 16'd25, 16'd94);
    do_op("shr_b", 4'd14, 16'd25, 16'd94);
    do_op("shl_b", 4'd15, 16'd25, 16'd94);
    do_op("shl_a_drop", 4'd13, 16'h8001, 16'h0000);
    do_op("shr_b_drop", 4'd14, 16'h0000, 16'h8001);

    // Switching unit clears the previous one
    do_op("switch_to_add", 4'd0, 16'sd1, 16'sd2);

    // Reset asserted mid-operation clears outputs at once and drops the op
    @(negedge clk);
    alu_fn = 4'd2;
    A      = 16'sd7;
    B      = 16'sd9;
    #2;
    rst = 1'b0;
    #1;
    check_outputs("reset_async", exp_t'(0));
    @(posedge clk);
    #1;
    check_outputs("reset_drop_op", exp_t'(0));
    @(negedge clk);
    rst = 1'b1;
    do_op("after_reset_sub", 4'd1, 16'sd10, 16'sd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
